// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master round-robin arbiter in front of the single-port data RAM.
// Optional ARB_LOCK_EN adds mN_lock inputs that let the last owner keep the RAM.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
`ifdef ARB_LOCK_EN
    input  logic              m0_lock,
`endif
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
`ifdef ARB_LOCK_EN
    input  logic              m1_lock,
`endif
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_out,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_in
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic owner;
    logic last_grant;
    logic lat_write;
    logic req_any;
    logic grant_sel;
    logic do_grant;
    logic do_capture;

    // Both requesting: the master that did not win last time goes next.
    always_comb begin
        req_any   = m0_req | m1_req;
        grant_sel = 1'b0;
        if (m0_req && m1_req) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = m1_req;
        end
`ifdef ARB_LOCK_EN
        if (last_grant ? (m1_req && m1_lock) : (m0_req && m0_lock)) begin
            grant_sel = last_grant;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_any) state_nx = ACCESS;
            ACCESS:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ram_write is decoded from state so an async reset drops it at once.
    always_comb begin
        do_grant   = (state == IDLE) && req_any;
        do_capture = (state == ACCESS);
        ram_write  = (state == ACCESS) && lat_write;
    end

    // ram_addr/ram_out double as the latched request fields, so they hold between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_write  <= 1'b0;
            ram_addr   <= '0;
            ram_out    <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            m0_ack <= do_capture && !owner;
            m1_ack <= do_capture && owner;
            if (do_grant) begin
                owner      <= grant_sel;
                last_grant <= grant_sel;
                lat_write  <= grant_sel ? m1_write : m0_write;
                ram_addr   <= grant_sel ? m1_addr  : m0_addr;
                ram_out    <= grant_sel ? m1_wdata : m0_wdata;
            end
            if (do_capture && !lat_write) begin
                if (owner) begin
                    m1_rdata <= ram_in;
                end else begin
                    m0_rdata <= ram_in;
                end
            end
        end
    end

endmodule
